// File: rtl/little_alchemy_pkg.sv
// Shared constants and state types for the little_alchemy AXI-Lite slave.
package little_alchemy_pkg;

    // Word indices (addr[4:2]) of the register map
    localparam logic [2:0] IDX_ELEM_A  = 3'd0;
    localparam logic [2:0] IDX_ELEM_B  = 3'd1;
    localparam logic [2:0] IDX_SCRATCH = 3'd2;
    localparam logic [2:0] IDX_LAUNCH  = 3'd3;
    localparam logic [2:0] IDX_RESULT  = 3'd4;
    localparam logic [2:0] IDX_STATUS  = 3'd5;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA} rd_state_e;

    // Byte-masked merge of new write data into an existing register value
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/little_alchemy_axil_slave_if.sv
// AXI-Lite slave bus plus the combiner command/response sideband.
interface little_alchemy_axil_slave_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   s00_axi_awaddr;
    logic [2:0]          s00_axi_awprot;
    logic                s00_axi_awvalid;
    logic                s00_axi_awready;
    logic [DATA_W-1:0]   s00_axi_wdata;
    logic [DATA_W/8-1:0] s00_axi_wstrb;
    logic                s00_axi_wvalid;
    logic                s00_axi_wready;
    logic [1:0]          s00_axi_bresp;
    logic                s00_axi_bvalid;
    logic                s00_axi_bready;
    logic [ADDR_W-1:0]   s00_axi_araddr;
    logic [2:0]          s00_axi_arprot;
    logic                s00_axi_arvalid;
    logic                s00_axi_arready;
    logic [DATA_W-1:0]   s00_axi_rdata;
    logic [1:0]          s00_axi_rresp;
    logic                s00_axi_rvalid;
    logic                s00_axi_rready;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [31:0]         cmd_elem_a;
    logic [31:0]         cmd_elem_b;
    logic                rsp_valid;
    logic [31:0]         rsp_result;

    modport slave (
        input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        output s00_axi_awready,
        input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        output s00_axi_wready,
        output s00_axi_bresp, s00_axi_bvalid,
        input  s00_axi_bready,
        input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
        output s00_axi_arready,
        output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        input  s00_axi_rready,
        output cmd_valid, cmd_elem_a, cmd_elem_b,
        input  cmd_ready, rsp_valid, rsp_result
    );

    modport master (
        output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        input  s00_axi_awready,
        output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        input  s00_axi_wready,
        input  s00_axi_bresp, s00_axi_bvalid,
        output s00_axi_bready,
        output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
        input  s00_axi_arready,
        input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        output s00_axi_rready,
        input  cmd_valid, cmd_elem_a, cmd_elem_b,
        output cmd_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/la_cmd_launcher.sv
// Owns busy/done state, the combiner command handshake and RESULT capture.
module la_cmd_launcher (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        launch_i,
    input  logic [31:0] elem_a_i,
    input  logic [31:0] elem_b_i,
    input  logic        done_clr_i,
    input  logic        cmd_ready_i,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_result_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        cmd_valid_o,
    output logic [31:0] cmd_elem_a_o,
    output logic [31:0] cmd_elem_b_o
);
    logic        busy_q, busy_d, done_q, done_d, cmd_valid_q, cmd_valid_d;
    logic [31:0] a_q, b_q, result_q;
    logic        start, finish;

    // A launch only starts while idle; a response only counts while busy
    assign start  = launch_i && !busy_q;
    assign finish = rsp_valid_i && busy_q;

    // Next-state for busy/done/cmd_valid; a done set beats a same-cycle W1C
    always_comb begin
        busy_d      = busy_q;
        done_d      = done_q;
        cmd_valid_d = cmd_valid_q;
        if (cmd_valid_q && cmd_ready_i) cmd_valid_d = 1'b0;
        if (start) begin
            busy_d      = 1'b1;
            cmd_valid_d = 1'b1;
        end
        if (done_clr_i) done_d = 1'b0;
        if (finish) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    // State registers; operands are frozen at launch so they stay stable
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_valid_q <= cmd_valid_d;
            if (start) begin
                a_q <= elem_a_i;
                b_q <= elem_b_i;
            end
            if (finish) result_q <= rsp_result_i;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign cmd_valid_o  = cmd_valid_q;
    assign cmd_elem_a_o = a_q;
    assign cmd_elem_b_o = b_q;
endmodule

// File: rtl/little_alchemy_axil_slave.sv
// AXI-Lite register slave: write/read FSMs, registers 0-3, and the launcher.
module little_alchemy_axil_slave
    import little_alchemy_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_areset,
    little_alchemy_axil_slave_if.slave    bus
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    wr_state_e         w_q, w_d;
    rd_state_e         r_q, r_d;
    logic [2:0]        awidx_q;
    logic [DW-1:0]     wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q, bresp_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DW-1:0]     regs_q [4];

    logic              aw_hs, w_hs, ar_hs, wr_en;
    logic [2:0]        wr_idx, rd_idx;
    logic [DW-1:0]     wr_data;
    logic [3:0]        wr_strb;
    logic              busy, done;
    logic [31:0]       result;
    logic [AW-1:0]     araddr;

    assign araddr = bus.s00_axi_araddr;
    assign rd_idx = araddr[4:2];

    // Readies are held low during reset even though the FSMs sit in idle
    assign bus.s00_axi_awready = !s00_axi_areset && (w_q == W_IDLE || w_q == W_DATA);
    assign bus.s00_axi_wready  = !s00_axi_areset && (w_q == W_IDLE || w_q == W_ADDR);
    assign bus.s00_axi_arready = !s00_axi_areset && (r_q == R_IDLE);
    assign bus.s00_axi_bvalid  = (w_q == W_RESP);
    assign bus.s00_axi_bresp   = bresp_q;
    assign bus.s00_axi_rvalid  = (r_q == R_DATA);
    assign bus.s00_axi_rdata   = rdata_q;
    assign bus.s00_axi_rresp   = rresp_q;

    assign aw_hs = bus.s00_axi_awvalid && bus.s00_axi_awready;
    assign w_hs  = bus.s00_axi_wvalid  && bus.s00_axi_wready;
    assign ar_hs = bus.s00_axi_arvalid && bus.s00_axi_arready;

    // The write commits in the cycle the second of AW/W is taken
    assign wr_idx  = aw_hs ? bus.s00_axi_awaddr[4:2] : awidx_q;
    assign wr_data = w_hs  ? bus.s00_axi_wdata : wdata_q;
    assign wr_strb = w_hs  ? bus.s00_axi_wstrb : wstrb_q;
    assign wr_en   = (w_q == W_IDLE && aw_hs && w_hs) ||
                     (w_q == W_ADDR && w_hs) ||
                     (w_q == W_DATA && aw_hs);

    // Write FSM next state and the response code for the committing write
    always_comb begin
        w_d     = w_q;
        bresp_d = bresp_q;
        case (w_q)
            W_IDLE: if (aw_hs && w_hs) w_d = W_RESP;
                    else if (aw_hs)    w_d = W_ADDR;
                    else if (w_hs)     w_d = W_DATA;
            W_ADDR: if (w_hs)  w_d = W_RESP;
            W_DATA: if (aw_hs) w_d = W_RESP;
            W_RESP: if (bus.s00_axi_bready) w_d = W_IDLE;
            default: w_d = W_IDLE;
        endcase
        if (wr_en)
            bresp_d = (wr_idx >= 3'd6 || (wr_idx == IDX_LAUNCH && busy)) ? RESP_SLVERR : RESP_OKAY;
    end

    // Read FSM next state and the read-data mux sampled on the AR handshake
    always_comb begin
        r_d     = r_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        case (r_q)
            R_IDLE: if (ar_hs) r_d = R_DATA;
            R_DATA: if (bus.s00_axi_rready) r_d = R_IDLE;
            default: r_d = R_IDLE;
        endcase
        if (ar_hs) begin
            rresp_d = RESP_OKAY;
            case (rd_idx)
                IDX_ELEM_A, IDX_ELEM_B, IDX_SCRATCH, IDX_LAUNCH: rdata_d = regs_q[rd_idx[1:0]];
                IDX_RESULT: rdata_d = result;
                IDX_STATUS: rdata_d = {{(DW-2){1'b0}}, done, busy};
                default: begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end
            endcase
        end
    end

    // FSM state, channel capture, responses and registers 0-3
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            w_q     <= W_IDLE;
            r_q     <= R_IDLE;
            awidx_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= RESP_OKAY;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            w_q     <= w_d;
            r_q     <= r_d;
            bresp_q <= bresp_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            if (aw_hs) awidx_q <= bus.s00_axi_awaddr[4:2];
            if (w_hs) begin
                wdata_q <= bus.s00_axi_wdata;
                wstrb_q <= bus.s00_axi_wstrb;
            end
            for (int i = 0; i < 4; i++)
                if (wr_en && wr_idx == 3'(i))
                    regs_q[i] <= apply_strb(regs_q[i], wr_data, wr_strb);
        end
    end

    la_cmd_launcher u_launch (
        .clk_i        (s00_axi_aclk),
        .rst_i        (s00_axi_areset),
        .launch_i     (wr_en && wr_idx == IDX_LAUNCH),
        .elem_a_i     (regs_q[0]),
        .elem_b_i     (regs_q[1]),
        .done_clr_i   (wr_en && wr_idx == IDX_STATUS && wr_strb[0] && wr_data[1]),
        .cmd_ready_i  (bus.cmd_ready),
        .rsp_valid_i  (bus.rsp_valid),
        .rsp_result_i (bus.rsp_result),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .cmd_valid_o  (bus.cmd_valid),
        .cmd_elem_a_o (bus.cmd_elem_a),
        .cmd_elem_b_o (bus.cmd_elem_b)
    );
endmodule

// File: tb/tb_little_alchemy_axil_slave.sv
// Scoreboard bench for little_alchemy_axil_slave.
module tb_little_alchemy_axil_slave;
    import little_alchemy_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   chk_cnt = 0;
    int   err_cnt = 0;
    int   cmd_hs_cnt = 0;

    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    logic [63:0] exp_cmd[$];

    little_alchemy_axil_slave_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    little_alchemy_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .bus            (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write-response scoreboard
    always @(negedge clk) if (!rst && bus.s00_axi_bvalid && bus.s00_axi_bready) begin
        if (exp_b.size() == 0) chk("b_unexp", 64'(bus.s00_axi_bvalid), 0);
        else chk("bresp", 64'(bus.s00_axi_bresp), 64'(exp_b.pop_front()));
    end

    // Read-response scoreboard
    always @(negedge clk) if (!rst && bus.s00_axi_rvalid && bus.s00_axi_rready) begin
        if (exp_r.size() == 0) chk("r_unexp", 64'(bus.s00_axi_rvalid), 0);
        else begin
            logic [33:0] e;
            e = exp_r.pop_front();
            chk("rdata", 64'(bus.s00_axi_rdata), 64'(e[31:0]));
            chk("rresp", 64'(bus.s00_axi_rresp), 64'(e[33:32]));
        end
    end

    // Command scoreboard: operands checked every cycle cmd_valid is up
    always @(negedge clk) if (!rst && bus.cmd_valid) begin
        if (exp_cmd.size() == 0) chk("cmd_unexp", 64'(bus.cmd_valid), 0);
        else begin
            chk("cmd_a", 64'(bus.cmd_elem_a), 64'(exp_cmd[0][63:32]));
            chk("cmd_b", 64'(bus.cmd_elem_b), 64'(exp_cmd[0][31:0]));
            if (bus.cmd_ready) begin
                void'(exp_cmd.pop_front());
                cmd_hs_cnt++;
            end
        end
    end

    task automatic axi_wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] resp, input int w_lead);
        bit aw_done = 0, w_done = 0, b_seen = 0;
        int n = 0, hs_cyc = 0, b_cyc = 0;
        exp_b.push_back(resp);
        @(posedge clk); #1;
        bus.s00_axi_wvalid = 1'b1; bus.s00_axi_wdata = data; bus.s00_axi_wstrb = strb;
        if (w_lead == 0) begin bus.s00_axi_awvalid = 1'b1; bus.s00_axi_awaddr = addr; end
        while (!(aw_done && w_done) && n < 30) begin
            @(negedge clk);
            if (bus.s00_axi_awvalid && bus.s00_axi_awready) begin aw_done = 1; hs_cyc = cyc; end
            if (bus.s00_axi_wvalid && bus.s00_axi_wready) begin w_done = 1; hs_cyc = cyc; end
            @(posedge clk); #1; n++;
            if (aw_done) bus.s00_axi_awvalid = 1'b0;
            if (w_done)  bus.s00_axi_wvalid  = 1'b0;
            if (!aw_done && n >= w_lead) begin bus.s00_axi_awvalid = 1'b1; bus.s00_axi_awaddr = addr; end
        end
        chk("wr_accept", 64'(aw_done && w_done), 1);
        n = 0;
        while (!b_seen && n < 30) begin
            @(negedge clk); n++;
            if (bus.s00_axi_bvalid) begin b_seen = 1; b_cyc = cyc; end
        end
        chk("b_lat", 64'(b_cyc - hs_cyc), 1);
    endtask

    task automatic axi_rd(input logic [4:0] addr, input logic [31:0] data, input logic [1:0] resp);
        bit ar_done = 0, r_seen = 0;
        int n = 0, hs_cyc = 0, r_cyc = 0;
        exp_r.push_back({resp, data});
        @(posedge clk); #1;
        bus.s00_axi_arvalid = 1'b1; bus.s00_axi_araddr = addr;
        while (!ar_done && n < 30) begin
            @(negedge clk);
            if (bus.s00_axi_arready) begin ar_done = 1; hs_cyc = cyc; end
            @(posedge clk); #1; n++;
        end
        bus.s00_axi_arvalid = 1'b0;
        chk("ar_accept", 64'(ar_done), 1);
        n = 0;
        while (!r_seen && n < 30) begin
            @(negedge clk); n++;
            if (bus.s00_axi_rvalid) begin r_seen = 1; r_cyc = cyc; end
        end
        chk("r_lat", 64'(r_cyc - hs_cyc), 1);
    endtask

    task automatic rsp_pulse(input logic [31:0] v);
        @(posedge clk); #1;
        bus.rsp_valid = 1'b1; bus.rsp_result = v;
        @(posedge clk); #1;
        bus.rsp_valid = 1'b0;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_awready"}, 64'(bus.s00_axi_awready), 0);
        chk({tag, "_wready"},  64'(bus.s00_axi_wready), 0);
        chk({tag, "_arready"}, 64'(bus.s00_axi_arready), 0);
        chk({tag, "_bvalid"},  64'(bus.s00_axi_bvalid), 0);
        chk({tag, "_rvalid"},  64'(bus.s00_axi_rvalid), 0);
        chk({tag, "_cmdv"},    64'(bus.cmd_valid), 0);
        chk({tag, "_resp"},    64'({bus.s00_axi_bresp, bus.s00_axi_rresp}), 0);
        chk({tag, "_rdata"},   64'(bus.s00_axi_rdata), 0);
    endtask

    initial begin
        bus.s00_axi_awaddr = '0; bus.s00_axi_awprot = '0; bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wdata = '0; bus.s00_axi_wstrb = '0; bus.s00_axi_wvalid = 1'b0;
        bus.s00_axi_bready = 1'b1;
        bus.s00_axi_araddr = '0; bus.s00_axi_arprot = '0; bus.s00_axi_arvalid = 1'b0;
        bus.s00_axi_rready = 1'b1;
        bus.cmd_ready = 1'b1; bus.rsp_valid = 1'b0; bus.rsp_result = '0;

        repeat (2) @(negedge clk);
        chk_outs_zero("rst");
        @(posedge clk); #1 rst = 1'b0;

        // Basic writes with one launch, then readback
        axi_wr(5'h00, 32'd1, 4'hF, RESP_OKAY, 0);
        axi_wr(5'h04, 32'd2, 4'hF, RESP_OKAY, 0);
        axi_wr(5'h08, 32'd3, 4'hF, RESP_OKAY, 0);
        exp_cmd.push_back({32'd1, 32'd2});
        axi_wr(5'h0C, 32'd4, 4'hF, RESP_OKAY, 0);
        axi_rd(5'h00, 32'd1, RESP_OKAY);
        axi_rd(5'h04, 32'd2, RESP_OKAY);
        axi_rd(5'h08, 32'd3, RESP_OKAY);
        axi_rd(5'h0C, 32'd4, RESP_OKAY);
        chk("cmd_count1", 64'(cmd_hs_cnt), 1);
        rsp_pulse(32'h55);
        axi_rd(5'h10, 32'h55, RESP_OKAY);
        axi_rd(5'h14, 32'h2, RESP_OKAY);
        axi_wr(5'h14, 32'h2, 4'hF, RESP_OKAY, 0);
        axi_rd(5'h14, 32'h0, RESP_OKAY);

        // W leads AW by three cycles
        axi_wr(5'h08, 32'hDEADBEEF, 4'hF, RESP_OKAY, 3);
        axi_rd(5'h08, 32'hDEADBEEF, RESP_OKAY);

        // Byte strobes
        axi_wr(5'h00, 32'h0, 4'hF, RESP_OKAY, 0);
        axi_wr(5'h00, 32'hFFFFFFFF, 4'b0101, RESP_OKAY, 0);
        axi_rd(5'h00, 32'h00FF00FF, RESP_OKAY);

        // Launch with backpressure held five cycles
        axi_wr(5'h00, 32'h10, 4'hF, RESP_OKAY, 0);
        axi_wr(5'h04, 32'h20, 4'hF, RESP_OKAY, 0);
        bus.cmd_ready = 1'b0;
        exp_cmd.push_back({32'h10, 32'h20});
        axi_wr(5'h0C, 32'h1, 4'hF, RESP_OKAY, 0);
        for (int i = 0; i < 5; i++) begin
            chk("cmd_hold", 64'(bus.cmd_valid), 1);
            @(negedge clk);
        end
        axi_rd(5'h14, 32'h1, RESP_OKAY);
        @(posedge clk); #1 bus.cmd_ready = 1'b1;
        @(posedge clk); #1 bus.cmd_ready = 1'b0;
        @(negedge clk);
        chk("cmd_drop", 64'(bus.cmd_valid), 0);

        // Launch while busy, unmapped read
        axi_wr(5'h0C, 32'h7, 4'hF, RESP_SLVERR, 0);
        axi_rd(5'h0C, 32'h7, RESP_OKAY);
        axi_rd(5'h18, 32'h0, RESP_SLVERR);
        chk("cmd_count2", 64'(cmd_hs_cnt), 2);
        rsp_pulse(32'h2A);
        axi_rd(5'h14, 32'h2, RESP_OKAY);
        axi_rd(5'h10, 32'h2A, RESP_OKAY);
        axi_wr(5'h10, 32'h5, 4'hF, RESP_OKAY, 0);
        axi_rd(5'h10, 32'h2A, RESP_OKAY);
        axi_wr(5'h14, 32'h2, 4'hF, RESP_OKAY, 0);
        axi_rd(5'h14, 32'h0, RESP_OKAY);
        rsp_pulse(32'h99);
        axi_rd(5'h10, 32'h2A, RESP_OKAY);
        axi_rd(5'h14, 32'h0, RESP_OKAY);
        axi_wr(5'h1C, 32'hABCD, 4'hF, RESP_SLVERR, 0);
        axi_rd(5'h1C, 32'h0, RESP_SLVERR);

        // Reset while a command is pending
        axi_wr(5'h00, 32'h11, 4'hF, RESP_OKAY, 0);
        axi_wr(5'h04, 32'h22, 4'hF, RESP_OKAY, 0);
        exp_cmd.push_back({32'h11, 32'h22});
        axi_wr(5'h0C, 32'h1, 4'hF, RESP_OKAY, 0);
        chk("cmd_pend", 64'(bus.cmd_valid), 1);
        @(posedge clk); #1 rst = 1'b1;
        exp_cmd.delete();
        @(negedge clk);
        chk_outs_zero("mid_rst");
        @(posedge clk); #1 rst = 1'b0;
        rsp_pulse(32'h77);
        axi_rd(5'h10, 32'h0, RESP_OKAY);
        axi_rd(5'h14, 32'h0, RESP_OKAY);
        axi_rd(5'h00, 32'h0, RESP_OKAY);

        // Same-cycle read and write of SCRATCH: read sees the old value
        fork
            axi_wr(5'h08, 32'h1234, 4'hF, RESP_OKAY, 0);
            axi_rd(5'h08, 32'h0, RESP_OKAY);
        join
        axi_rd(5'h08, 32'h1234, RESP_OKAY);

        repeat (3) @(negedge clk);
        chk("sb_b_empty", 64'(exp_b.size()), 0);
        chk("sb_r_empty", 64'(exp_r.size()), 0);
        chk("sb_cmd_empty", 64'(exp_cmd.size()), 0);
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end
endmodule
